// File: rtl/serial_add_sched.sv
// rtl/serial_add_sched.sv - round-robin scheduler sharing one bit-serial adder among N requesters
// Optional SERIAL_ADD_SCHED_STATS_EN adds a saturating op_count output.
module serial_add_sched #(
  parameter int N       = 4,
  parameter int ADD_LAT = 10,
  parameter int W       = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   res,
  output logic [N-1:0]   res_valid,
  output logic           busy,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic           add_start,
  output logic           add_clr,
  input  logic [W-1:0]   add_out
`ifdef SERIAL_ADD_SCHED_STATS_EN
  ,
  output logic [15:0]    op_count
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RELEASE
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IW-1:0]  r_rr_ptr;
  logic [IW-1:0]  r_idx;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_add_a;
  logic [W-1:0]   r_add_b;
  logic [W-1:0]   r_res;
  logic           w_found;
  logic [IW-1:0]  w_sel;
  logic [N-1:0]   w_onehot;
  int             w_j;

  // First requester at or above rr_ptr, wrapping, so the last-served index has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_rr_ptr;
    w_j     = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(r_rr_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!w_found && req[w_j]) begin
        w_found = 1'b1;
        w_sel   = IW'(w_j);
      end
    end
  end

  assign w_onehot = {{(N-1){1'b0}}, 1'b1} << r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ack         = '0;
    res_valid   = '0;
    add_start   = 1'b0;
    add_clr     = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:    if (w_found) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        add_start   = 1'b1;
        ack         = w_onehot;
        w_state_nxt = S_WAIT;
      end
      // Leaving when the count is about to hit ADD_LAT-1 puts CAPTURE ADD_LAT cycles after ISSUE.
      S_WAIT:    if (r_cnt == CW'(ADD_LAT - 2)) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_RELEASE;
      S_RELEASE: begin
        res_valid   = w_onehot;
        add_clr     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_add_a  <= '0;
      r_add_b  <= '0;
      r_res    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_add_a <= a_in[int'(w_sel)*W +: W];
            r_add_b <= b_in[int'(w_sel)*W +: W];
            r_idx   <= w_sel;
          end
        end
        S_ISSUE:   r_cnt <= '0;
        S_WAIT:    r_cnt <= r_cnt + 1'b1;
        S_CAPTURE: r_res <= add_out;
        S_RELEASE: r_rr_ptr <= (r_idx == IW'(N - 1)) ? '0 : r_idx + 1'b1;
        default:   r_cnt <= '0;
      endcase
    end
  end

  assign add_a = r_add_a;
  assign add_b = r_add_b;
  assign res   = r_res;

`ifdef SERIAL_ADD_SCHED_STATS_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                r_op_count <= '0;
    else if (r_state == S_RELEASE && r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_serial_add_sched.sv
// tb/tb_serial_add_sched.sv - directed bench for serial_add_sched with a fixed-latency adder model
module tb_serial_add_sched;
  localparam int N = 4, W = 8, ADD_LAT = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_in = '0, b_in = '0;
  logic [N-1:0]   ack, res_valid;
  logic [W-1:0]   res, add_a, add_b, add_out;
  logic           busy, add_start, add_clr;
`ifdef SERIAL_ADD_SCHED_STATS_EN
  logic [15:0]    op_count;
`endif

  serial_add_sched #(.N(N), .ADD_LAT(ADD_LAT), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .res(res), .res_valid(res_valid), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_start(add_start), .add_clr(add_clr),
    .add_out(add_out)
`ifdef SERIAL_ADD_SCHED_STATS_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, start_cyc = -100, issue_cyc = 0, prev_issue = 0;
  logic [W-1:0] m_sum = '0;
  logic [N-1:0] nxt_req = '0;
  logic [N*W-1:0] nxt_a = '0, nxt_b = '0;

  // Adder model: sum is presented only in the cycle exactly ADD_LAT after the start pulse.
  always @(posedge clk) begin
    if (add_start) begin
      start_cyc <= cyc;
      m_sum     <= add_a + add_b;
    end
    cyc <= cyc + 1;
  end
  assign add_out = (cyc == start_cyc + ADD_LAT) ? m_sum : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at an IDLE-cycle negedge with req already driven; returns at the RELEASE negedge.
  task automatic do_op(input string tag, input int idx, input logic [7:0] ea, input logic [7:0] eb,
                       input logic [7:0] es);
    int qe;
    qe = 0;
    @(negedge clk);
    chk({tag, "_ack"}, 32'(ack), 32'(1 << idx));
    chk({tag, "_start"}, 32'(add_start), 1);
    chk({tag, "_a"}, 32'(add_a), 32'(ea));
    chk({tag, "_b"}, 32'(add_b), 32'(eb));
    chk({tag, "_busy"}, 32'(busy), 1);
    issue_cyc = cyc;
    req  = nxt_req;
    a_in = nxt_a;
    b_in = nxt_b;
    for (int k = 1; k <= ADD_LAT; k++) begin
      @(negedge clk);
      if (add_a !== ea || add_b !== eb || ack !== '0 || res_valid !== '0 ||
          add_start !== 1'b0 || add_clr !== 1'b0 || busy !== 1'b1) qe++;
    end
    chk({tag, "_quiet"}, 32'(qe), 0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(res_valid), 32'(1 << idx));
    chk({tag, "_res"}, 32'(res), 32'(es));
    chk({tag, "_clr"}, 32'(add_clr), 1);
    chk({tag, "_noack"}, 32'(ack), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_pulses", {30'd0, add_start, add_clr}, 0);
    chk("rst_regs", {8'd0, add_a, add_b, res}, 0);
    rst = 1'b0;

    req = 4'b0001; a_in[0 +: 8] = 8'd3; b_in[0 +: 8] = 8'd5;
    nxt_req = '0; nxt_a = a_in; nxt_b = b_in;
    do_op("single", 0, 8'd3, 8'd5, 8'd8);
    @(negedge clk);
    chk("single_idle", 32'(busy), 0);
    chk("single_hold", 32'(res), 8);

    req = 4'b0100; a_in[16 +: 8] = 8'd200; b_in[16 +: 8] = 8'd100;
    nxt_a = a_in; nxt_b = b_in;
    do_op("wrap", 2, 8'd200, 8'd100, 8'd44);
    @(negedge clk);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_in = {8'd40, 8'd30, 8'd20, 8'd10};
    b_in = {8'd4, 8'd3, 8'd2, 8'd1};
    req = 4'b1111; nxt_req = 4'b1111; nxt_a = a_in; nxt_b = b_in;
    do_op("c0", 0, 8'd10, 8'd1, 8'd11);
    @(negedge clk);
    do_op("c1", 1, 8'd20, 8'd2, 8'd22);
    @(negedge clk);
    do_op("c2", 2, 8'd30, 8'd3, 8'd33);
    @(negedge clk);
    do_op("c3", 3, 8'd40, 8'd4, 8'd44);
    @(negedge clk);
    do_op("c4", 0, 8'd10, 8'd1, 8'd11);
    @(negedge clk);
`ifdef SERIAL_ADD_SCHED_STATS_EN
    chk("stats_5", 32'(op_count), 5);
`endif
    req = 4'b1010; nxt_req = 4'b1010;
    do_op("c5", 1, 8'd20, 8'd2, 8'd22);
    @(negedge clk);
    nxt_req = '0;
    do_op("c6", 3, 8'd40, 8'd4, 8'd44);
    @(negedge clk);

    req = 4'b0001; a_in[0 +: 8] = 8'd7; b_in[0 +: 8] = 8'd9;
    nxt_req = 4'b0001; nxt_a = a_in; nxt_b = b_in;
    nxt_a[0 +: 8] = 8'd100; nxt_b[0 +: 8] = 8'd50;
    do_op("bb0", 0, 8'd7, 8'd9, 8'd16);
    prev_issue = issue_cyc;
    @(negedge clk);
    chk("bb_gap_pulses", {30'd0, add_start, add_clr}, 0);
    nxt_a[0 +: 8] = 8'd255; nxt_b[0 +: 8] = 8'd1;
    do_op("bb1", 0, 8'd100, 8'd50, 8'd150);
    chk("bb1_spacing", 32'(issue_cyc - prev_issue), 32'(ADD_LAT + 3));
    prev_issue = issue_cyc;
    @(negedge clk);
    nxt_req = '0;
    do_op("bb2", 0, 8'd255, 8'd1, 8'd0);
    chk("bb2_spacing", 32'(issue_cyc - prev_issue), 32'(ADD_LAT + 3));
    @(negedge clk);

    req = 4'b0001; a_in[0 +: 8] = 8'd1; b_in[0 +: 8] = 8'd1;
    @(negedge clk);
    chk("rw_ack", 32'(ack), 1);
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rw_busy", 32'(busy), 0);
    chk("rw_outs", {24'd0, ack, res_valid}, 0);
    chk("rw_pulses", {30'd0, add_start, add_clr}, 0);
    chk("rw_regs", {8'd0, add_a, add_b, res}, 0);
`ifdef SERIAL_ADD_SCHED_STATS_EN
    chk("stats_rst", 32'(op_count), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1000; a_in[24 +: 8] = 8'd5; b_in[24 +: 8] = 8'd6;
    nxt_req = '0; nxt_a = a_in; nxt_b = b_in;
    do_op("after_rst", 3, 8'd5, 8'd6, 8'd11);
    @(negedge clk);
`ifdef SERIAL_ADD_SCHED_STATS_EN
    chk("stats_1", 32'(op_count), 1);
`endif
    chk("final_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
